// File: rtl/cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Package : cpu_pkg
// Brief   : Shared widths and the fetch queue entry type for the CPU front end.
// Rev     : 1.0  initial release
// ============================================================================
package cpu_pkg;

  // Address (PC) width and instruction word width used across the core
  localparam int AW = 8;
  localparam int IW = 16;

  // One queued fetch: the address it was read from and the returned word
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] insn;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO of fetch_entry_t with flush, occupancy count,
//           full/empty flags and a first-word-fall-through head.
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t      mem_q [DEPTH];
  fetch_entry_t      mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              do_push;
  logic              do_pop;

  // Status flags and head word come straight from the registered state
  always_comb begin
    full  = (count_q == (PW+1)'(DEPTH));
    empty = (count_q == '0);
    count = count_q;
    head  = mem_q[rd_ptr_q];
  end

  // Next-state: a pop only takes effect when there is a head; a push into a
  // full queue is dropped unless a pop frees the slot in the same cycle.
  // Flush discards everything, including a same-cycle push.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + (PW+1)'(1);
      end else if (!do_push && do_pop) begin
        count_d = count_q - (PW+1)'(1);
      end
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while not counted as occupied
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : Instruction fetch front end. Drives the ROM from the PC, tracks
//           reads in flight, queues returned words with their addresses and
//           steers the PC (hold on back-pressure, redirect on taken branch).
// Rev     : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter int AW      = 8,   // must equal cpu_pkg::AW (queue entry layout)
  parameter int IW      = 16,  // must equal cpu_pkg::IW
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          pc_in,
  output logic                   jump_en,
  output logic [AW-1:0]          jump_addr,
  output logic [AW-1:0]          mem_addr,
  output logic                   mem_en,
  input  logic [IW-1:0]          mem_rdata,
  input  logic                   redirect_en,
  input  logic [AW-1:0]          redirect_addr,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [IW-1:0]          inst_data,
  output logic [AW-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0] count
);

  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  // Wide enough to sum queue count and in-flight reads without overflow
  localparam int SW = 16;

  logic [MEM_LAT-1:0] trk_valid_q, trk_valid_d;
  logic [AW-1:0]      trk_addr_q [MEM_LAT];
  logic [AW-1:0]      trk_addr_d [MEM_LAT];

  logic [SW-1:0]      inflight;
  logic [SW-1:0]      occupancy;
  logic               issue;

  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  // Number of ROM reads issued but not yet written into the queue
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + SW'(trk_valid_q[i]);
    end
  end

  // Issue / hold / redirect steering. The credit check deliberately ignores a
  // same-cycle pop so inst_ready never reaches jump_en combinationally.
  always_comb begin
    occupancy = SW'(fifo_count) + inflight;
    issue     = !reset && !redirect_en && (occupancy < SW'(DEPTH));
    mem_en    = issue;
    mem_addr  = pc_in;
    jump_en   = 1'b0;
    jump_addr = pc_in;
    if (reset) begin
      jump_en = 1'b0;
    end else if (redirect_en) begin
      jump_en   = 1'b1;
      jump_addr = redirect_addr;
    end else if (!issue) begin
      jump_en   = 1'b1;
      jump_addr = pc_in;
    end
  end

  // Read tracker: a MEM_LAT-deep shift of {valid, addr}; a redirect kills
  // every read still in flight so no stale word reaches the queue.
  always_comb begin
    trk_valid_d[0] = issue;
    trk_addr_d[0]  = pc_in;
    for (int i = 1; i < MEM_LAT; i++) begin
      trk_valid_d[i] = trk_valid_q[i-1];
      trk_addr_d[i]  = trk_addr_q[i-1];
    end
    if (redirect_en) begin
      trk_valid_d = '0;
    end
  end

  // Tracker registers; only the valid bits need clearing on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_valid_q <= '0;
    end else begin
      trk_valid_q <= trk_valid_d;
    end
    trk_addr_q <= trk_addr_d;
  end

  // Queue write port fed by the tracker output and the ROM data
  always_comb begin
    push_entry.pc   = trk_addr_q[MEM_LAT-1];
    push_entry.insn = mem_rdata;
    fifo_push       = trk_valid_q[MEM_LAT-1] && !redirect_en;
    fifo_pop        = inst_ready;
  end

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_en),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Decode-facing view of the queue head
  always_comb begin
    inst_valid = !fifo_empty;
    inst_data  = head_entry.insn;
    inst_pc    = head_entry.pc;
    count      = fifo_count;
  end

  // The issue credit must never let a word arrive at a full queue unpopped
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(fifo_push && fifo_full && !fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_fetch_queue
// Brief   : Self-checking bench for fetch_queue with a PC register model, a
//           1-cycle ROM model (mem[a] = {8'hA5, a}) and an in-order scoreboard.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fetch_queue;

  localparam int AW      = 8;
  localparam int IW      = 16;
  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 1;
  localparam int NV      = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] pc_in;
  logic          jump_en;
  logic [AW-1:0] jump_addr;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [IW-1:0] mem_rdata;
  logic          redirect_en = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] inst_pc;
  logic [2:0]    count;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] sb[$];

  typedef struct {
    logic          ready;
    logic          redir;
    logic [AW-1:0] raddr;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic [2:0]    exp_count;
    logic          exp_mem_en;
    logic          exp_jump_en;
    logic [AW-1:0] exp_jaddr;
    logic [AW-1:0] exp_maddr;
  } vec_t;

  vec_t vt[NV];

  always #5 clk = ~clk;

  fetch_queue #(
    .AW      (AW),
    .IW      (IW),
    .DEPTH   (DEPTH),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc_in         (pc_in),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .mem_addr      (mem_addr),
    .mem_en        (mem_en),
    .mem_rdata     (mem_rdata),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .count         (count)
  );

  // PC register: reset to 0, load on jump, else increment
  always @(posedge clk) begin
    if (reset)        pc_in <= '0;
    else if (jump_en) pc_in <= jump_addr;
    else              pc_in <= pc_in + 8'd1;
  end

  // ROM with one cycle of read latency
  always @(posedge clk) begin
    mem_rdata <= {8'hA5, mem_addr};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: issued addresses queued in order, checked on each handshake
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pop", {24'd0, inst_pc}, 32'hFFFF_FFFF);
        end else begin
          logic [AW-1:0] e;
          e = sb.pop_front();
          chk("sb_pc", {24'd0, inst_pc}, {24'd0, e});
          chk("sb_data", {16'd0, inst_data}, {16'd0, 8'hA5, e});
        end
      end
      if (redirect_en) sb.delete();
      else if (mem_en) sb.push_back(mem_addr);
    end
  end

  task automatic do_reset(input int n, input logic rdy);
    @(posedge clk); #1;
    reset = 1'b1; redirect_en = 1'b0; redirect_addr = '0; inst_ready = rdy;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Expect n consecutive head words start, start+1, ... once valid appears
  task automatic stream_check(input logic [AW-1:0] start, input int n,
                              input int budget, input string tag);
    int w;
    logic [AW-1:0] e;
    w = 0;
    @(negedge clk);
    while (!inst_valid && w < budget) begin
      @(negedge clk);
      w++;
    end
    if (!inst_valid) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      e = start + AW'(k);
      chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
      chk({tag, "_pc"}, {24'd0, inst_pc}, {24'd0, e});
      chk({tag, "_data"}, {16'd0, inst_data}, {16'd0, 8'hA5, e});
    end
  endtask

  task automatic wait_full(input string tag);
    int w;
    w = 0;
    @(negedge clk);
    while (count != 3'd4 && w < 12) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_count_full"}, {29'd0, count}, 32'd4);
  endtask

  initial begin
    // ready, redir, raddr | valid, pc, count, mem_en, jump_en, jaddr, maddr
    vt[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 8'h01};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd1, 1'b1, 1'b0, 8'h00, 8'h02};
    vt[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd2, 1'b1, 1'b0, 8'h00, 8'h03};
    vt[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b1, 8'h04, 8'h04};
    vt[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b1, 8'h04, 8'h04};
    vt[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 1'b1, 8'h04, 8'h04};
    vt[7]  = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h00, 3'd4, 1'b0, 1'b1, 8'h40, 8'h04};
    vt[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 8'h40};
    vt[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 8'h41};
    vt[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 3'd1, 1'b1, 1'b0, 8'h00, 8'h42};
    vt[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 3'd1, 1'b1, 1'b0, 8'h00, 8'h43};

    // Table: fill to full under back-pressure, hold, redirect while holding
    do_reset(3, 1'b0);
    for (int i = 0; i < NV; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      inst_ready    = vt[i].ready;
      redirect_en   = vt[i].redir;
      redirect_addr = vt[i].raddr;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vt[i].exp_valid});
      if (vt[i].exp_valid) begin
        chk($sformatf("v%0d_pc", i), {24'd0, inst_pc}, {24'd0, vt[i].exp_pc});
        chk($sformatf("v%0d_data", i), {16'd0, inst_data}, {16'd0, 8'hA5, vt[i].exp_pc});
      end
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, vt[i].exp_count});
      chk($sformatf("v%0d_mem_en", i), {31'd0, mem_en}, {31'd0, vt[i].exp_mem_en});
      chk($sformatf("v%0d_jump_en", i), {31'd0, jump_en}, {31'd0, vt[i].exp_jump_en});
      if (vt[i].exp_jump_en) begin
        chk($sformatf("v%0d_jaddr", i), {24'd0, jump_addr}, {24'd0, vt[i].exp_jaddr});
      end
      chk($sformatf("v%0d_maddr", i), {24'd0, mem_addr}, {24'd0, vt[i].exp_maddr});
    end

    // 1: streaming from reset, first valid two cycles after release
    do_reset(3, 1'b1);
    @(negedge clk);
    chk("t1_reset_count", {29'd0, count}, 32'd0);
    chk("t1_reset_jump_en", {31'd0, jump_en}, 32'd0);
    chk("t1_c0_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("t1_c1_valid", {31'd0, inst_valid}, 32'd0);
    stream_check(8'h00, 8, 0, "t1");

    // 2: back-pressure from reset, hold at 4, then in-order drain
    do_reset(3, 1'b0);
    wait_full("t2");
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk("t2_hold_jump_en", {31'd0, jump_en}, 32'd1);
      chk("t2_hold_jaddr", {24'd0, jump_addr}, 32'h04);
      chk("t2_hold_pc", {24'd0, pc_in}, 32'h04);
      chk("t2_hold_head", {24'd0, inst_pc}, 32'h00);
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    stream_check(8'h00, 8, 0, "t2");

    // 3: redirect to 8'h40 while the head is pc 3
    do_reset(3, 1'b1);
    stream_check(8'h00, 3, 4, "t3a");
    @(posedge clk); #1;
    redirect_en = 1'b1; redirect_addr = 8'h40;
    @(negedge clk);
    chk("t3_head_at_redirect", {24'd0, inst_pc}, 32'h03);
    chk("t3_redir_jump_en", {31'd0, jump_en}, 32'd1);
    chk("t3_redir_jaddr", {24'd0, jump_addr}, 32'h40);
    chk("t3_redir_mem_en", {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1;
    redirect_en = 1'b0;
    @(negedge clk);
    chk("t3_flush_count", {29'd0, count}, 32'd0);
    chk("t3_flush_valid", {31'd0, inst_valid}, 32'd0);
    stream_check(8'h40, 4, 4, "t3b");

    // 4: redirect near the top of the address space, wrap to 0
    @(posedge clk); #1;
    redirect_en = 1'b1; redirect_addr = 8'hFE;
    @(negedge clk);
    chk("t4_redir_jaddr", {24'd0, jump_addr}, 32'hFE);
    @(posedge clk); #1;
    redirect_en = 1'b0;
    stream_check(8'hFE, 4, 6, "t4");

    // 6: full queue, one-cycle reset, restart from pc 0
    do_reset(1, 1'b0);
    wait_full("t6");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    chk("t6_after_reset_valid", {31'd0, inst_valid}, 32'd0);
    chk("t6_after_reset_count", {29'd0, count}, 32'd0);
    stream_check(8'h00, 4, 1, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
